// File: rtl/mining_pkg.sv
// Shared types and constants for the mining control path.
// Used by nonce_search_ctrl and digest_cmp_serial.
package mining_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_NONCE,
        S_START,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RD,
        S_DECIDE
    } nonce_state_t;

    localparam int HEADER_WORDS = 20;
    localparam int NONCE_WORD   = 19;
    localparam int DIGEST_WORDS = 8;

    localparam int TGT_MSW_HI = 255;
    localparam int TGT_MSW_LO = 224;

    // Word i of the target, counted from the most significant end.
    function automatic logic [31:0] target_word(
        input logic [255:0] t,
        input logic [2:0]   i
    );
        logic [255:0] s;
        s = t << {i, 5'd0};
        return s[TGT_MSW_HI:TGT_MSW_LO];
    endfunction

endpackage

// File: rtl/digest_cmp_serial.sv
// Word-serial unsigned less-than compare, most significant word first.
// Flags hold until the next clear; equal operands leave lt low.
module digest_cmp_serial (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        valid,
    input  logic [31:0] d,
    input  logic [31:0] t,
    output logic        eq,
    output logic        lt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eq <= 1'b1;
            lt <= 1'b0;
        end else if (clear) begin
            eq <= 1'b1;
            lt <= 1'b0;
        end else if (valid) begin
            if (eq && (d < t))
                lt <= 1'b1;
            if (d != t)
                eq <= 1'b0;
        end
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce sweep controller around the SHA-256 hasher.
// Define NONCE_SEARCH_STATS_EN to add the saturating hash_count output.
module nonce_search_ctrl #(
    parameter int NONCE_WORD   = mining_pkg::NONCE_WORD,
    parameter int DIGEST_WORDS = mining_pkg::DIGEST_WORDS
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         go,
    input  logic         stop,
    input  logic [15:0]  message_addr,
    input  logic [15:0]  output_addr,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  found_nonce,
    output logic         sha_start,
    input  logic         sha_done,
    output logic         sha_owns_bus,
`ifdef NONCE_SEARCH_STATS_EN
    output logic [31:0]  hash_count,
`endif
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    output logic [31:0]  mem_write_data,
    input  logic [31:0]  mem_read_data
);

    import mining_pkg::*;

    localparam int CW = $clog2(DIGEST_WORDS + 1);
    localparam logic [CW-1:0] RD_LAST = CW'(DIGEST_WORDS);
    localparam logic [15:0]   NW_OFF  = 16'(NONCE_WORD);

    nonce_state_t   state_q, state_d;
    logic [15:0]    msg_q, msg_d;
    logic [15:0]    out_q, out_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    end_q, end_d;
    logic [255:0]   tgt_q, tgt_d;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;

    logic           busy_d, found_d, exh_d, start_d, owns_d, we_d;
    logic [31:0]    fnonce_d, wdata_d;
    logic [15:0]    addr_d;

    logic           launch, last, cmp_clr, cmp_vld;
    logic           cmp_eq, cmp_lt;
    logic [2:0]     cmp_idx;

    assign launch = (state_q == S_IDLE) && go;
    assign last   = (nonce_q == end_q);

    assign msg_d = launch ? message_addr : msg_q;
    assign out_d = launch ? output_addr  : out_q;
    assign end_d = launch ? nonce_end    : end_q;
    assign tgt_d = launch ? target       : tgt_q;

    // Word i-1 arrives while the RD counter shows i.
    assign cmp_clr = (state_q == S_WAIT_HI) && sha_done;
    assign cmp_vld = (state_q == S_RD) && (rd_cnt_q != '0);
    assign cmp_idx = cmp_vld ? 3'(rd_cnt_q - 1'b1) : 3'd0;

    digest_cmp_serial u_cmp (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cmp_clr),
        .valid   (cmp_vld),
        .d       (mem_read_data),
        .t       (target_word(tgt_q, cmp_idx)),
        .eq      (cmp_eq),
        .lt      (cmp_lt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            out_q    <= '0;
            nonce_q  <= '0;
            end_q    <= '0;
            tgt_q    <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            out_q    <= out_d;
            nonce_q  <= nonce_d;
            end_q    <= end_d;
            tgt_q    <= tgt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        nonce_d  = nonce_q;
        rd_cnt_d = rd_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_WR_NONCE;
                    nonce_d = nonce_start;
                end
            end
            S_WR_NONCE: state_d = S_START;
            S_START:    state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!sha_done)
                    state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (sha_done) begin
                    state_d  = S_RD;
                    rd_cnt_d = '0;
                end
            end
            S_RD: begin
                if (rd_cnt_q == RD_LAST)
                    state_d = S_DECIDE;
                else
                    rd_cnt_d = rd_cnt_q + 1'b1;
            end
            S_DECIDE: begin
                if (cmp_lt || last || stop) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_NONCE;
                    nonce_d = nonce_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        busy_d   = (state_d != S_IDLE);
        we_d     = (state_d == S_WR_NONCE);
        start_d  = (state_d == S_START);
        owns_d   = (state_d == S_START) || (state_d == S_WAIT_LO) ||
                   (state_d == S_WAIT_HI);
        addr_d   = mem_addr;
        wdata_d  = mem_write_data;
        found_d  = found;
        exh_d    = exhausted;
        fnonce_d = found_nonce;
        if (state_d == S_WR_NONCE) begin
            addr_d  = msg_d + NW_OFF;
            wdata_d = nonce_d;
        end else if ((state_d == S_RD) && (rd_cnt_d != RD_LAST)) begin
            addr_d = out_q + 16'(rd_cnt_d);
        end
        if (launch) begin
            found_d = 1'b0;
            exh_d   = 1'b0;
        end
        if (state_q == S_DECIDE) begin
            if (cmp_lt) begin
                found_d  = 1'b1;
                fnonce_d = nonce_q;
            end else if (last) begin
                exh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            found          <= 1'b0;
            exhausted      <= 1'b0;
            found_nonce    <= '0;
            sha_start      <= 1'b0;
            sha_owns_bus   <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            busy           <= busy_d;
            found          <= found_d;
            exhausted      <= exh_d;
            found_nonce    <= fnonce_d;
            sha_start      <= start_d;
            sha_owns_bus   <= owns_d;
            mem_we         <= we_d;
            mem_addr       <= addr_d;
            mem_write_data <= wdata_d;
        end
    end

`ifdef NONCE_SEARCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hash_count <= '0;
        else if (launch)
            hash_count <= '0;
        else if ((state_q == S_DECIDE) && (hash_count != 32'hFFFF_FFFF))
            hash_count <= hash_count + 32'd1;
    end
`endif

endmodule

// File: doc/nonce_search_ctrl.md
# nonce_search_ctrl

Nonce-sweep controller for the mining datapath. It wraps the SHA-256 hasher: it writes each candidate nonce into word 19 of the 20-word block header in memory, starts the hasher, and waits for `done`. It then reads back the 8-word digest and compares it against a 256-bit target. It reports the first nonce whose digest is strictly below the target, or reports exhaustion of the requested range.

## Interface

Parameters:
- `NONCE_WORD`, default 19: word offset of the nonce within the header at `message_addr`.
- `DIGEST_WORDS`, default 8: number of digest words read from `output_addr`.

Ports:
- `clk`  in  1  clock. Memory is synchronous: data for the address registered on edge N is valid on `mem_read_data` after edge N+1.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `go`  in  1  single-cycle start pulse; ignored while `busy`.
- `stop`  in  1  level; ends the sweep after the in-flight hash.
- `message_addr`  in  16  header base address; sampled on `go`.
- `output_addr`  in  16  digest base address; sampled on `go`.
- `nonce_start`  in  32  first nonce; sampled on `go`.
- `nonce_end`  in  32  last nonce, inclusive; sampled on `go`.
- `target`  in  256  threshold; bits [255:224] are compared against digest word 0; sampled on `go`.
- `busy`  out  1  high from the edge after `go` until the sweep ends.
- `found`  out  1  sticky until the next `go`.
- `exhausted`  out  1  sticky until the next `go`.
- `found_nonce`  out  32  valid while `found`.
- `sha_start`  out  1  start pulse to the hasher.
- `sha_done`  in  1  hasher `done` (high while the hasher is idle).
- `sha_owns_bus`  out  1  top-level memory mux select; 1 means the hasher drives memory.
- `mem_we`, `mem_addr`[15:0], `mem_write_data`[31:0]  out  controller memory port.
- `mem_read_data`  in  32  memory read data.

## Operation

States and transitions:
- `IDLE`
  - On `go`: latch all sampled inputs, `nonce <= nonce_start`, clear `found`/`exhausted`, go to `WR_NONCE`.
- `WR_NONCE` (1 cycle)
  - `mem_we=1`, `mem_addr = msg + NONCE_WORD`, data = `nonce`.
  - Go to `START`.
- `START` (1 cycle)
  - `mem_we=0`, `sha_start=1`, `sha_owns_bus=1`.
  - Go to `WAIT_LO`.
- `WAIT_LO`
  - Wait for `sha_done=0`, then go to `WAIT_HI`.
- `WAIT_HI`
  - Wait for `sha_done=1`.
  - Then `sha_owns_bus=0`, go to `RD`.
- `RD` (`DIGEST_WORDS`+1 cycles)
  - Cycle i issues `out + i` for i < 8.
  - Cycle i ≥ 1 consumes word i-1 into the compare.
- `DECIDE` (1 cycle)
  - If `lt`: `found=1`, `found_nonce = nonce`, go to `IDLE`.
  - Else if `nonce == nonce_end` or `stop`: `exhausted = (nonce == nonce_end)`, go to `IDLE`.
  - Else: `nonce <= nonce + 1` (mod 2^32), go to `WR_NONCE`.

Compare rules:
- Word-serial, MSW first, flags `eq` (init 1) and `lt` (init 0).
- On each word: if `eq` and `d < t` then `lt=1`; if `d != t` then `eq=0`.
- Equal digest and target means no hit (strict less-than).

Boundary conditions:
- `nonce_start > nonce_end`: the sweep wraps through 0xFFFFFFFF to 0.
- `nonce_start == nonce_end`: exactly one hash.
- `stop` is never applied mid-hash. If a hit and `stop` coincide in `DECIDE`, the hit wins.
- `go` while `busy`: ignored, latched values unchanged.
- `reset_n` low at any time: immediate return to `IDLE`.

## Timing

- Reset values: `busy=0`, `found=0`, `exhausted=0`, `found_nonce=0`, `sha_start=0`, `sha_owns_bus=0`, `mem_we=0`, `mem_addr=0`, `mem_write_data=0`. All outputs are registered.
- Per-nonce overhead outside the hasher: `WR_NONCE` 1 + `START` 1 + `WAIT_HI` exit 1 + `RD` 9 + `DECIDE` 1 = 13 cycles, plus the `WAIT_LO` dwell of ≥1 cycle.
- `busy` falls on the same edge that sets `found` or `exhausted`.
- `mem_we` is high only in `WR_NONCE`.

## Configuration

- `NONCE_SEARCH_STATS_EN` defined:
  - Adds output `hash_count`[31:0].
  - Cleared on `go` and on reset.
  - Increments once per `DECIDE`, saturating at 0xFFFFFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure

- Shared package `mining_pkg`:
  - State enum `nonce_state_t`.
  - Constants `HEADER_WORDS=20`, `NONCE_WORD=19`, `DIGEST_WORDS=8`.
  - Localparam for the target word slice.
- One sub-module, `digest_cmp_serial`: holds the `eq`/`lt` flags with `clear`/`valid` inputs. It also serves the future share-difficulty checker.

## Test plan

- Stub hasher writes a fixed digest 0x00000000_0000FFFF_…; `target` all-ones, `nonce_start=0x10` → one hash, `found=1`, `found_nonce=0x10`, mem[msg+19]=0x10.
- `target=0`, `nonce_start=5`, `nonce_end=7` → three hashes, mem[msg+19] last written 7, `exhausted=1`, `found=0`.
- Stub digest exactly equal to `target` → no hit. Same run with `target` = digest+1 → hit.
- `nonce_start=0xFFFFFFFF`, `nonce_end=0`, `target=0` → nonces 0xFFFFFFFF then 0, `exhausted` after 2 hashes; with STATS, `hash_count=2`.
- `stop` raised during hash 1 of range 0..100 → `DECIDE` ends the sweep, `exhausted=0`, `found=0`, `busy=0`. A `go` while busy changes nothing.
- `reset_n` pulsed low during `RD` → all outputs at reset values next cycle; a fresh `go` completes normally.
